// File: rtl/chain_seq_pkg.sv
// Shared types and helpers for the chain toggle sequencer.
// Default lat_t width matches the sequencer's default CNT_W.
package chain_seq_pkg;

  localparam int unsigned LatW = 8;

  typedef logic [LatW-1:0] lat_t;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StDrive,
    StWait
  } state_e;

  // An odd number of inverting stages flips the chain output relative to its input.
  function automatic logic inv_of(input int unsigned stages);
    return stages[0];
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, async active-low reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/chain_toggle_sequencer.sv
// Toggles an external inverter/delay chain and measures per-edge round-trip latency.
// Define CHAIN_SEQ_STATS_EN to add min_lat/max_lat latency statistics outputs.
module chain_toggle_sequencer
  import chain_seq_pkg::*;
#(
  parameter int unsigned STAGES  = 5,
  parameter int unsigned CNT_W   = LatW,
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned NUM_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num_toggles,
  output logic             chain_in,
  input  logic             chain_out,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             polarity_err,
  output logic [CNT_W-1:0] last_lat,
  output logic [NUM_W-1:0] edges_done
`ifdef CHAIN_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat
`endif
);

  localparam logic             Inv        = inv_of(STAGES);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             chain_in_q, chain_in_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] last_lat_q, last_lat_d;
  logic [NUM_W-1:0] edges_q, edges_d;
  logic [NUM_W-1:0] target_q, target_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             pol_q, pol_d;

  logic             out_s;
  logic             match;
  logic [CNT_W-1:0] lat_inc;
  logic [NUM_W-1:0] edges_inc;

`ifdef CHAIN_SEQ_STATS_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
`endif

  sync2 u_sync_out (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (chain_out),
    .q     (out_s)
  );

  // Compared against the current chain_in, so in WAIT this checks the edge just sent.
  assign match     = (out_s == (chain_in_q ^ Inv));
  assign lat_inc   = (lat_q == '1) ? lat_q : lat_q + 1'b1;
  assign edges_inc = (edges_q == '1) ? edges_q : edges_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    chain_in_d = chain_in_q;
    lat_d      = lat_q;
    last_lat_d = last_lat_q;
    edges_d    = edges_q;
    target_d   = target_q;
    done_d     = 1'b0;
    tmo_d      = tmo_q;
    pol_d      = pol_q;
`ifdef CHAIN_SEQ_STATS_EN
    min_d      = min_q;
    max_d      = max_q;
`endif

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            target_d = num_toggles;
            edges_d  = '0;
            tmo_d    = 1'b0;
            pol_d    = 1'b0;
`ifdef CHAIN_SEQ_STATS_EN
            min_d    = '1;
            max_d    = '0;
`endif
            if (num_toggles == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = StCheck;
            end
          end
        end
        StCheck: begin
          if (!match) begin
            pol_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StDrive;
          end
        end
        StDrive: begin
          chain_in_d = ~chain_in_q;
          lat_d      = '0;
          state_d    = StWait;
        end
        StWait: begin
          lat_d = lat_inc;
          if (match) begin
            last_lat_d = lat_inc;
            edges_d    = edges_inc;
`ifdef CHAIN_SEQ_STATS_EN
            if (lat_inc < min_q) min_d = lat_inc;
            if (lat_inc > max_q) max_d = lat_inc;
`endif
            if (edges_inc == target_q) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StDrive;
            end
          end else if (lat_inc == TimeoutCnt) begin
            tmo_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      chain_in_q <= 1'b0;
      lat_q      <= '0;
      last_lat_q <= '0;
      edges_q    <= '0;
      target_q   <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      pol_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chain_in_q <= chain_in_d;
      lat_q      <= lat_d;
      last_lat_q <= last_lat_d;
      edges_q    <= edges_d;
      target_q   <= target_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      pol_q      <= pol_d;
    end
  end

`ifdef CHAIN_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_lat = min_q;
  assign max_lat = max_q;
`endif

  assign chain_in     = chain_in_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign timeout_err  = tmo_q;
  assign polarity_err = pol_q;
  assign last_lat     = last_lat_q;
  assign edges_done   = edges_q;

endmodule

// File: tb/tb_chain_toggle_sequencer.sv
// Directed bench for chain_toggle_sequencer with a behavioural inverting delay-chain model.
// Stats checks are compiled in when CHAIN_SEQ_STATS_EN is defined.
module tb_chain_toggle_sequencer;
  import chain_seq_pkg::*;

  localparam int unsigned STAGES  = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 200;
  localparam int unsigned NUM_W   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NUM_W-1:0] num_toggles = '0;
  logic             chain_in;
  logic             chain_out;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             polarity_err;
  lat_t             last_lat;
  logic [NUM_W-1:0] edges_done;
`ifdef CHAIN_SEQ_STATS_EN
  lat_t             min_lat;
  lat_t             max_lat;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chain_toggle_sequencer #(
    .STAGES  (STAGES),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .NUM_W   (NUM_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .num_toggles  (num_toggles),
    .chain_in     (chain_in),
    .chain_out    (chain_out),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .polarity_err (polarity_err),
    .last_lat     (last_lat),
    .edges_done   (edges_done)
`ifdef CHAIN_SEQ_STATS_EN
    ,
    .min_lat      (min_lat),
    .max_lat      (max_lat)
`endif
  );

  // Chain model: D counts the DUT's chain_in flop, so chain_out flips D-1 edges after
  // chain_in changes; reported latency is then D+2.
  logic       seen;
  logic       model_out;
  logic       stuck = 1'b0;
  logic       freeze_mode = 1'b0;
  logic       model_clr = 1'b0;
  logic [7:0] age;
  logic [7:0] cur_dly;
  logic [1:0] nedge;
  logic [1:0] idx;
  logic [7:0] dly_tab [4];

  assign idx       = model_clr ? 2'd0 : nedge;
  assign chain_out = stuck ? 1'b0 : model_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= 1'b0;
      age       <= 8'hff;
      cur_dly   <= 8'd3;
      nedge     <= 2'd0;
      model_out <= 1'b1;
    end else if (chain_in != seen) begin
      seen    <= chain_in;
      age     <= 8'd1;
      cur_dly <= dly_tab[idx];
      nedge   <= idx + 2'd1;
      if (dly_tab[idx] == 8'd2 && !(freeze_mode && idx >= 2'd1)) model_out <= ~chain_in;
    end else begin
      if (model_clr) nedge <= 2'd0;
      if (age != 8'hff) age <= age + 8'd1;
      if (!(freeze_mode && nedge >= 2'd2) && (int'(age) + 1 >= int'(cur_dly) - 1))
        model_out <= ~seen;
    end
  end

  task automatic pulse_start(input int n);
    @(negedge clk);
    start       = 1'b1;
    num_toggles = NUM_W'(n);
    model_clr   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    model_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cyc, output int dones);
    cyc   = 0;
    dones = 0;
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (chain_in !== 1'b0) begin errors++; $display("FAIL rst_chain_in: got %b want 0", chain_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_tmo: got %b want 0", timeout_err); end
    checks++; if (polarity_err !== 1'b0) begin errors++; $display("FAIL rst_pol: got %b want 0", polarity_err); end
    checks++; if (last_lat !== 8'd0) begin errors++; $display("FAIL rst_last_lat: got %0d want 0", last_lat); end
    checks++; if (edges_done !== 5'd0) begin errors++; $display("FAIL rst_edges: got %0d want 0", edges_done); end
`ifdef CHAIN_SEQ_STATS_EN
    checks++; if (min_lat !== 8'd0) begin errors++; $display("FAIL rst_min_lat: got %0d want 0", min_lat); end
    checks++; if (max_lat !== 8'd0) begin errors++; $display("FAIL rst_max_lat: got %0d want 0", max_lat); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_toggle_run();
    int cyc;
    int dones;
    logic [NUM_W-1:0] prev;
    cyc   = 0;
    dones = 0;
    pulse_start(4);
    prev = edges_done;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      if (edges_done != prev) begin
        prev = edges_done;
        checks++; if (last_lat !== 8'd5) begin errors++; $display("FAIL run_edge_lat: got %0d want 5", last_lat); end
      end
    end
    checks++; if (cyc !== 25) begin errors++; $display("FAIL run_cycles: got %0d want 25", cyc); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL run_dones: got %0d want 1", dones); end
    checks++; if (edges_done !== 5'd4) begin errors++; $display("FAIL run_edges: got %0d want 4", edges_done); end
    checks++; if (chain_in !== 1'b0) begin errors++; $display("FAIL run_chain_in: got %b want 0", chain_in); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL run_tmo: got %b want 0", timeout_err); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done_width: got %b want 0", done); end
  endtask

  task automatic test_polarity();
    stuck = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pol_busy_check: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pol_busy_fall: got %b want 0", busy); end
    checks++; if (polarity_err !== 1'b1) begin errors++; $display("FAIL pol_err: got %b want 1", polarity_err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pol_done: got %b want 0", done); end
    checks++; if (chain_in !== 1'b0) begin errors++; $display("FAIL pol_chain_in: got %b want 0", chain_in); end
    stuck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    int dones;
    freeze_mode = 1'b1;
    pulse_start(3);
    checks++; if (polarity_err !== 1'b0) begin errors++; $display("FAIL tmo_pol_clear: got %b want 0", polarity_err); end
    wait_idle(400, cyc, dones);
    checks++; if (cyc !== 208) begin errors++; $display("FAIL tmo_cycles: got %0d want 208", cyc); end
    checks++; if (dones !== 0) begin errors++; $display("FAIL tmo_dones: got %0d want 0", dones); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", timeout_err); end
    checks++; if (edges_done !== 5'd1) begin errors++; $display("FAIL tmo_edges: got %0d want 1", edges_done); end
    checks++; if (last_lat !== 8'd5) begin errors++; $display("FAIL tmo_last_lat: got %0d want 5", last_lat); end
    freeze_mode = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    int cyc;
    int dones;
    pulse_start(3);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL abt_tmo_clear: got %b want 0", timeout_err); end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abt_busy: got %b want 0", busy); end
    checks++; if (chain_in !== 1'b1) begin errors++; $display("FAIL abt_chain_in: got %b want 1", chain_in); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abt_done: got %b want 0", done); end
    checks++; if (edges_done !== 5'd0) begin errors++; $display("FAIL abt_edges: got %0d want 0", edges_done); end
    repeat (4) @(negedge clk);
    checks++; if (chain_in !== 1'b1) begin errors++; $display("FAIL abt_hold: got %b want 1", chain_in); end
    pulse_start(2);
    wait_idle(100, cyc, dones);
    checks++; if (cyc !== 13) begin errors++; $display("FAIL abt_rerun_cycles: got %0d want 13", cyc); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL abt_rerun_dones: got %0d want 1", dones); end
    checks++; if (edges_done !== 5'd2) begin errors++; $display("FAIL abt_rerun_edges: got %0d want 2", edges_done); end
    checks++; if (chain_in !== 1'b1) begin errors++; $display("FAIL abt_rerun_chain_in: got %b want 1", chain_in); end
    checks++; if (last_lat !== 8'd5) begin errors++; $display("FAIL abt_rerun_lat: got %0d want 5", last_lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    pulse_start(4);
    repeat (16) @(negedge clk);
    checks++; if (edges_done !== 5'd2) begin errors++; $display("FAIL mrst_pre_edges: got %0d want 2", edges_done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_pre_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
    checks++; if (chain_in !== 1'b0) begin errors++; $display("FAIL mrst_chain_in: got %b want 0", chain_in); end
    checks++; if (edges_done !== 5'd0) begin errors++; $display("FAIL mrst_edges: got %0d want 0", edges_done); end
    checks++; if (last_lat !== 8'd0) begin errors++; $display("FAIL mrst_last_lat: got %0d want 0", last_lat); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int dones;
    pulse_start(4);
    repeat (3) @(negedge clk);
    pulse_start(1);
    wait_idle(100, cyc, dones);
    checks++; if (cyc !== 20) begin errors++; $display("FAIL b2b_cycles: got %0d want 20", cyc); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_dones: got %0d want 1", dones); end
    checks++; if (edges_done !== 5'd4) begin errors++; $display("FAIL b2b_edges: got %0d want 4", edges_done); end
    @(negedge clk);
    pulse_start(0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
    checks++; if (edges_done !== 5'd0) begin errors++; $display("FAIL zero_edges: got %0d want 0", edges_done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", done); end
  endtask

`ifdef CHAIN_SEQ_STATS_EN
  task automatic test_stats();
    int cyc;
    int dones;
    dly_tab[0] = 8'd2;
    dly_tab[1] = 8'd6;
    dly_tab[2] = 8'd4;
    pulse_start(3);
    checks++; if (min_lat !== 8'hff) begin errors++; $display("FAIL st_min_init: got %0d want 255", min_lat); end
    checks++; if (max_lat !== 8'd0) begin errors++; $display("FAIL st_max_init: got %0d want 0", max_lat); end
    wait_idle(100, cyc, dones);
    checks++; if (cyc !== 22) begin errors++; $display("FAIL st_cycles: got %0d want 22", cyc); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL st_dones: got %0d want 1", dones); end
    checks++; if (min_lat !== 8'd4) begin errors++; $display("FAIL st_min: got %0d want 4", min_lat); end
    checks++; if (max_lat !== 8'd8) begin errors++; $display("FAIL st_max: got %0d want 8", max_lat); end
    checks++; if (last_lat !== 8'd6) begin errors++; $display("FAIL st_last_lat: got %0d want 6", last_lat); end
    for (int i = 0; i < 4; i++) dly_tab[i] = 8'd3;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) dly_tab[i] = 8'd3;
    test_reset();
    test_toggle_run();
    test_polarity();
    test_timeout();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
`ifdef CHAIN_SEQ_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
